// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP engine host-side memory.
//   IMG_W_LOG2 / ADDR_W / DATA_W : default geometry (128x128 image, 8-bit pixels)
//   IMG_W                        : image side length, for border arithmetic
//   LAST_ADDR                    : highest pixel address
//   state_e                      : host memory FSM states
package lbp_pkg;

  localparam int unsigned IMG_W_LOG2 = 7;
  localparam int unsigned ADDR_W     = 2 * IMG_W_LOG2;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned IMG_W      = 1 << IMG_W_LOG2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    LOAD,
    SERVE,
    DONE
  } state_e;

endpackage

// File: rtl/lbp_host_mem_if.sv
// Bus between the system/engine side (master) and lbp_host_mem (slave).
//   load_valid/load_data        : streaming image load
//   gray_ready/gray_req/addr/data : engine gray-pixel read
//   lbp_valid/addr/data, finish : engine result write and completion
//   done, rd_addr/rd_data       : result readback
//   wr_cnt                      : accepted result writes
//   err                         : protocol error flag, only with LBP_HOST_CHECK_EN
interface lbp_host_mem_if #(
  parameter int unsigned ADDR_W = lbp_pkg::ADDR_W,
  parameter int unsigned DATA_W = lbp_pkg::DATA_W
);

  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              gray_ready;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic [DATA_W-1:0] gray_data;
  logic              lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic [DATA_W-1:0] lbp_data;
  logic              finish;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   wr_cnt;
`ifdef LBP_HOST_CHECK_EN
  logic              err;
`endif

  modport master (
    output load_valid, load_data, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
           finish, rd_addr,
    input  gray_ready, gray_data, done, rd_data, wr_cnt
`ifdef LBP_HOST_CHECK_EN
    , input err
`endif
  );

  modport slave (
    input  load_valid, load_data, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data,
           finish, rd_addr,
    output gray_ready, gray_data, done, rd_data, wr_cnt
`ifdef LBP_HOST_CHECK_EN
    , output err
`endif
  );

endinterface

// File: rtl/lbp_dpram.sv
// Single-write-port memory with one asynchronous and one registered read port.
//   clk, reset          : clock; reset clears only the registered read data
//   we_i/waddr_i/wdata_i: synchronous write
//   araddr_i -> ardata_o: zero-latency read
//   rraddr_i -> rrdata_o: one-cycle-latency read
module lbp_dpram #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] araddr_i,
  output logic [DATA_W-1:0] ardata_o,
  input  logic [ADDR_W-1:0] rraddr_i,
  output logic [DATA_W-1:0] rrdata_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign ardata_o = mem[araddr_i];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rrdata_o <= '0;
    else       rrdata_o <= mem[rraddr_i];
  end

endmodule

// File: rtl/lbp_host_mem.sv
// Host-side memory responder for the LBP engine.
// Loads a square gray image from a stream, serves it to the engine, captures LBP
// results until finish, then offers registered readback of the results.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : lbp_host_mem_if slave modport (load, gray read, lbp write, readback)
// Optional: define LBP_HOST_CHECK_EN to add a sticky bus.err flag for duplicate
// writes and for lbp_valid/finish seen while still loading.
module lbp_host_mem #(
  parameter int unsigned IMG_W_LOG2 = lbp_pkg::IMG_W_LOG2,
  parameter int unsigned ADDR_W     = 2 * IMG_W_LOG2,
  parameter int unsigned DATA_W     = lbp_pkg::DATA_W
) (
  input  logic          clk,
  input  logic          reset,
  lbp_host_mem_if.slave bus
);
  import lbp_pkg::*;

  localparam logic [ADDR_W-1:0] LastAddr = '1;
  localparam logic [ADDR_W:0]   CntMax   = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              gray_ready_q;
  logic              done_q;
  logic [ADDR_W:0]   wr_cnt_q;

  logic              load_we;
  logic              lbp_we;
  logic [DATA_W-1:0] gray_rd;
  logic [DATA_W-1:0] unused_gray_rr;
  logic [DATA_W-1:0] unused_lbp_ard;
  logic              unused_gray_req;

  // gray_data is driven regardless of the request strobe.
  assign unused_gray_req = bus.gray_req;

  assign load_we = (state_q == LOAD) && bus.load_valid;
  assign lbp_we  = (state_q == SERVE) && bus.lbp_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= LOAD;
      ptr_q        <= '0;
      gray_ready_q <= 1'b0;
      done_q       <= 1'b0;
      wr_cnt_q     <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (bus.load_valid) begin
            ptr_q <= ptr_q + 1'b1;  // wraps to 0 on the final beat
            if (ptr_q == LastAddr) begin
              state_q      <= SERVE;
              gray_ready_q <= 1'b1;
            end
          end
        end
        SERVE: begin
          if (bus.lbp_valid && (wr_cnt_q != CntMax)) wr_cnt_q <= wr_cnt_q + 1'b1;
          if (bus.finish) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: ;
        default: state_q <= LOAD;
      endcase
    end
  end

  lbp_dpram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) gray_mem (
    .clk      (clk),
    .reset    (reset),
    .we_i     (load_we),
    .waddr_i  (ptr_q),
    .wdata_i  (bus.load_data),
    .araddr_i (bus.gray_addr),
    .ardata_o (gray_rd),
    .rraddr_i ('0),
    .rrdata_o (unused_gray_rr)
  );

  lbp_dpram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) lbp_mem (
    .clk      (clk),
    .reset    (reset),
    .we_i     (lbp_we),
    .waddr_i  (bus.lbp_addr),
    .wdata_i  (bus.lbp_data),
    .araddr_i ('0),
    .ardata_o (unused_lbp_ard),
    .rraddr_i (bus.rd_addr),
    .rrdata_o (bus.rd_data)
  );

  assign bus.gray_data  = (state_q == LOAD) ? '0 : gray_rd;
  assign bus.gray_ready = gray_ready_q;
  assign bus.done       = done_q;
  assign bus.wr_cnt     = wr_cnt_q;

`ifdef LBP_HOST_CHECK_EN
  logic [2**ADDR_W-1:0] written_q;
  logic                 err_q;

  // Only consulted in SERVE, so no reset is needed; cleared on the final load beat.
  always_ff @(posedge clk) begin
    if (load_we && (ptr_q == LastAddr)) written_q <= '0;
    else if (lbp_we)                    written_q[bus.lbp_addr] <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (lbp_we && written_q[bus.lbp_addr]) begin
      err_q <= 1'b1;
    end else if ((state_q == LOAD) && (bus.lbp_valid || bus.finish)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_lbp_host_mem.sv
module tb_lbp_host_mem;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 8;
  localparam int unsigned N  = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  lbp_host_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  lbp_host_mem #(
    .IMG_W_LOG2 (7),
    .ADDR_W     (AW),
    .DATA_W     (DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_image(input bit invert, input string tag);
    bit early = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = invert ? ~i[7:0] : i[7:0];
      if (bus.gray_ready !== 1'b0) early = 1'b1;
      tick();
    end
    bus.load_valid = 1'b0;
    check({tag, "_ready_low_while_loading"}, {31'b0, early}, 32'd0);
    check({tag, "_ready_after_last_beat"}, bus.gray_ready, 32'd1);
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.gray_req   = 1'b0;
    bus.gray_addr  = '0;
    bus.lbp_valid  = 1'b0;
    bus.lbp_addr   = '0;
    bus.lbp_data   = '0;
    bus.finish     = 1'b0;
    bus.rd_addr    = '0;
    reset          = 1'b0;
    #2;
    reset = 1'b1;
    #10;
    check("rst_gray_ready", bus.gray_ready, 32'd0);
    check("rst_done", bus.done, 32'd0);
    check("rst_rd_data", bus.rd_data, 32'd0);
    check("rst_wr_cnt", bus.wr_cnt, 32'd0);
`ifdef LBP_HOST_CHECK_EN
    check("rst_err", bus.err, 32'd0);
`endif
    tick();
    reset = 1'b0;

    // Engine activity during LOAD is ignored.
    bus.gray_addr = 14'h0007;
    #1;
    check("gray_data_zero_in_load", bus.gray_data, 32'd0);
    bus.lbp_valid = 1'b1;
    bus.lbp_addr  = 14'h0005;
    bus.lbp_data  = 8'h33;
    bus.finish    = 1'b1;
    tick();
    bus.lbp_valid = 1'b0;
    bus.finish    = 1'b0;
    tick();
    check("load_ignore_wr_cnt", bus.wr_cnt, 32'd0);
    check("load_ignore_done", bus.done, 32'd0);
    check("load_ignore_ready", bus.gray_ready, 32'd0);
`ifdef LBP_HOST_CHECK_EN
    check("err_on_load_misuse", bus.err, 32'd1);
    pulse_reset();
    check("err_cleared_by_reset", bus.err, 32'd0);
`endif

    // Full load with data = addr[7:0].
    load_image(1'b0, "load1");
    bus.gray_req  = 1'b1;
    bus.gray_addr = 14'h0081;
    #1;
    check("gray_0081", bus.gray_data, 32'h81);
    bus.gray_addr = 14'h3FFF;
    #1;
    check("gray_3fff", bus.gray_data, 32'hFF);
    bus.gray_req = 1'b0;

    // Write capture.
    bus.lbp_valid = 1'b1;
    bus.lbp_addr  = 14'h0081;
    bus.lbp_data  = 8'h5A;
    tick();
    bus.lbp_addr  = 14'h3F7E;
    bus.lbp_data  = 8'hC3;
    tick();
    bus.lbp_valid = 1'b0;
    check("wr_cnt_two", bus.wr_cnt, 32'd2);
    check("done_low_in_serve", bus.done, 32'd0);

    // load_valid in SERVE must not touch the image.
    bus.load_valid = 1'b1;
    bus.load_data  = 8'h77;
    tick();
    bus.load_valid = 1'b0;
    bus.gray_addr  = 14'h0000;
    #1;
    check("serve_ignores_load", bus.gray_data, 32'h00);

    // Write in the same cycle as finish is still taken.
    bus.lbp_valid = 1'b1;
    bus.lbp_addr  = 14'h0100;
    bus.lbp_data  = 8'h11;
    bus.finish    = 1'b1;
    tick();
    bus.lbp_valid = 1'b0;
    bus.finish    = 1'b0;
    check("done_after_finish", bus.done, 32'd1);
    check("wr_cnt_with_finish", bus.wr_cnt, 32'd3);
    check("ready_held_in_done", bus.gray_ready, 32'd1);

    bus.rd_addr = 14'h0081;
    tick();
    check("rd_0081", bus.rd_data, 32'h5A);
    bus.rd_addr = 14'h3F7E;
    tick();
    check("rd_3f7e", bus.rd_data, 32'hC3);
    bus.rd_addr = 14'h0100;
    tick();
    check("rd_0100", bus.rd_data, 32'h11);

    // Writes after DONE are ignored.
    bus.lbp_valid = 1'b1;
    bus.lbp_addr  = 14'h0100;
    bus.lbp_data  = 8'h22;
    tick();
    bus.lbp_valid = 1'b0;
    tick();
    check("done_ignores_wr_cnt", bus.wr_cnt, 32'd3);
    check("done_ignores_write", bus.rd_data, 32'h11);
    check("done_sticky", bus.done, 32'd1);
    bus.gray_addr = 14'h0042;
    #1;
    check("gray_in_done", bus.gray_data, 32'h42);
`ifdef LBP_HOST_CHECK_EN
    check("err_clean_unique", bus.err, 32'd0);
`endif

    // Reset from DONE is immediate and asynchronous.
    reset = 1'b1;
    #1;
    check("rst_done_ready", bus.gray_ready, 32'd0);
    check("rst_done_done", bus.done, 32'd0);
    check("rst_done_wr_cnt", bus.wr_cnt, 32'd0);
    tick();
    reset = 1'b0;

    // Partial load, reset, then full reload with inverted data.
    for (int i = 0; i < 100; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = i[7:0];
      tick();
    end
    bus.load_valid = 1'b0;
    pulse_reset();
    load_image(1'b1, "reload");
    bus.gray_addr = 14'h0005;
    #1;
    check("reload_gray_5", bus.gray_data, 32'hFA);
    bus.gray_addr = 14'h0000;
    #1;
    check("reload_gray_0", bus.gray_data, 32'hFF);

    // Unique write to every address, then saturation and a duplicate.
    for (int i = 0; i < N; i++) begin
      bus.lbp_valid = 1'b1;
      bus.lbp_addr  = i[13:0];
      bus.lbp_data  = i[7:0] ^ 8'h3C;
      tick();
    end
    bus.lbp_valid = 1'b0;
    check("wr_cnt_full", bus.wr_cnt, N);
`ifdef LBP_HOST_CHECK_EN
    check("err_full_unique", bus.err, 32'd0);
`endif
    bus.lbp_valid = 1'b1;
    bus.lbp_addr  = 14'h0200;
    bus.lbp_data  = 8'hA5;
    tick();
    bus.lbp_valid = 1'b0;
    check("wr_cnt_saturated", bus.wr_cnt, N);
`ifdef LBP_HOST_CHECK_EN
    check("err_duplicate", bus.err, 32'd1);
`endif
    bus.finish = 1'b1;
    tick();
    bus.finish  = 1'b0;
    bus.rd_addr = 14'h0200;
    tick();
    check("done_second_run", bus.done, 32'd1);
    check("rd_dup_overwrites", bus.rd_data, 32'hA5);
    bus.rd_addr = 14'h1234;
    tick();
    check("rd_1234", bus.rd_data, 32'h08);
`ifdef LBP_HOST_CHECK_EN
    check("err_sticky", bus.err, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
